buffer_arbiter: RTL

- Shares one `buffer` FIFO instance between NUM_REQ write requesters and NUM_REQ read requesters.
- Sequences the buffer's level handshake: raise we/re, wait for ack high, drop we/re, wait for ack low.
- Arbitrates round-robin within each direction and alternates between read and write when both are pending.
- Enforces the buffer's full/avail status and a handshake timeout, so no requester ever sees a buffer ERROR FULL or ERROR EMPTY access.

---
 rtl/buffer_arbiter_if.sv | 33 +++
 rtl/buffer_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_arbiter_if.sv
// Requester and buffer-side signals of buffer_arbiter, bundled for port connection.
// master: the arbiter's view; slave: requesters plus the shared buffer.
interface buffer_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_L  = 16
);
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ*DATA_L-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_done;
    logic [NUM_REQ-1:0]        rd_req;
    logic [NUM_REQ-1:0]        rd_done;
    logic [DATA_L-1:0]         rd_data;
    logic                      buf_we;
    logic                      buf_re;
    logic [DATA_L-1:0]         buf_din;
    logic [DATA_L-1:0]         buf_dout;
    logic                      buf_w_ack;
    logic                      buf_r_ack;
    logic                      buf_full;
    logic                      buf_avail;
    logic                      busy;
    logic                      err;

    modport master (
        input  wr_req, wr_data, rd_req, buf_dout, buf_w_ack, buf_r_ack, buf_full, buf_avail,
        output wr_done, rd_done, rd_data, buf_we, buf_re, buf_din, busy, err
    );

    modport slave (
        output wr_req, wr_data, rd_req, buf_dout, buf_w_ack, buf_r_ack, buf_full, buf_avail,
        input  wr_done, rd_done, rd_data, buf_we, buf_re, buf_din, busy, err
    );
endinterface

// File: rtl/buffer_arbiter.sv
// Shares one level-handshake FIFO between NUM_REQ writers and NUM_REQ readers:
// round-robin per direction, read/write alternation, full/avail gating, ack timeout.
module buffer_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_L  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    buffer_arbiter_if.master  bus
);
    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SET,
        S_W_CLR,
        S_R_SET,
        S_R_CLR
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       g_q, g_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                last_wr_q, last_wr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                buf_we_q, buf_we_d;
    logic                buf_re_q, buf_re_d;
    logic [DATA_L-1:0]   buf_din_q, buf_din_d;
    logic [DATA_L-1:0]   rd_data_q, rd_data_d;
    logic [NUM_REQ-1:0]  wr_done_q, wr_done_d;
    logic [NUM_REQ-1:0]  rd_done_q, rd_done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [PW-1:0]       wr_win, rd_win;
    logic [DATA_L-1:0]   wr_sel;
    logic                wr_elig, rd_elig, pick_wr, pick_rd;
    logic                done_active, to_hit, wr_fin, rd_fin;
    logic [CW-1:0]       count_inc;

    // First set request at or above ptr, wrapping modulo NUM_REQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [PW-1:0]      ptr);
        logic [PW-1:0] win;
        logic          found;
        int unsigned   idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[PW'(idx)]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
        return PW'((32'(g) + 32'd1) % NUM_REQ);
    endfunction

    always_comb begin
        wr_win = rr_pick(bus.wr_req, wr_ptr_q);
        rd_win = rr_pick(bus.rd_req, rd_ptr_q);
    end

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wr_win == PW'(i)) wr_sel = bus.wr_data[i*DATA_L +: DATA_L];
        end
    end

    // Grants wait one cycle after any done pulse so buffer status settles.
    always_comb begin
        done_active = (|wr_done_q) | (|rd_done_q);
        wr_elig     = (|bus.wr_req) & ~bus.buf_full;
        rd_elig     = (|bus.rd_req) & bus.buf_avail;
        pick_wr     = wr_elig & (~rd_elig | ~last_wr_q);
        pick_rd     = rd_elig & ~pick_wr;
        count_inc   = (count_q == '1) ? count_q : count_q + CW'(1);
        to_hit      = (count_inc >= TO_CNT);
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        last_wr_d = last_wr_q;
        count_d   = count_q;
        buf_we_d  = buf_we_q;
        buf_re_d  = buf_re_q;
        buf_din_d = buf_din_q;
        rd_data_d = rd_data_q;
        wr_done_d = '0;
        rd_done_d = '0;
        err_d     = err_q;
        wr_fin    = 1'b0;
        rd_fin    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!done_active) begin
                    if (pick_wr) begin
                        g_d       = wr_win;
                        buf_din_d = wr_sel;
                        buf_we_d  = 1'b1;
                        count_d   = '0;
                        state_d   = S_W_SET;
                    end else if (pick_rd) begin
                        g_d      = rd_win;
                        buf_re_d = 1'b1;
                        count_d  = '0;
                        state_d  = S_R_SET;
                    end
                end
            end
            S_W_SET: begin
                if (bus.buf_w_ack) begin
                    buf_we_d = 1'b0;
                    count_d  = '0;
                    state_d  = S_W_CLR;
                end else if (to_hit) begin
                    buf_we_d = 1'b0;
                    err_d    = 1'b1;
                    wr_fin   = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            S_W_CLR: begin
                if (!bus.buf_w_ack) begin
                    wr_fin = 1'b1;
                end else if (to_hit) begin
                    err_d  = 1'b1;
                    wr_fin = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            S_R_SET: begin
                if (bus.buf_r_ack) begin
                    buf_re_d  = 1'b0;
                    rd_data_d = bus.buf_dout;
                    count_d   = '0;
                    state_d   = S_R_CLR;
                end else if (to_hit) begin
                    buf_re_d  = 1'b0;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    rd_fin    = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            S_R_CLR: begin
                if (!bus.buf_r_ack) begin
                    rd_fin = 1'b1;
                end else if (to_hit) begin
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    rd_fin    = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Normal completion and timeout abort share the same exit path.
        if (wr_fin) begin
            wr_done_d = NUM_REQ'(1) << g_q;
            wr_ptr_d  = ptr_next(g_q);
            last_wr_d = 1'b1;
            count_d   = '0;
            state_d   = S_IDLE;
        end
        if (rd_fin) begin
            rd_done_d = NUM_REQ'(1) << g_q;
            rd_ptr_d  = ptr_next(g_q);
            last_wr_d = 1'b0;
            count_d   = '0;
            state_d   = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            last_wr_q <= 1'b0;
            count_q   <= '0;
            buf_we_q  <= 1'b0;
            buf_re_q  <= 1'b0;
            buf_din_q <= '0;
            rd_data_q <= '0;
            wr_done_q <= '0;
            rd_done_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            last_wr_q <= last_wr_d;
            count_q   <= count_d;
            buf_we_q  <= buf_we_d;
            buf_re_q  <= buf_re_d;
            buf_din_q <= buf_din_d;
            rd_data_q <= rd_data_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign bus.buf_we  = buf_we_q;
    assign bus.buf_re  = buf_re_q;
    assign bus.buf_din = buf_din_q;
    assign bus.rd_data = rd_data_q;
    assign bus.wr_done = wr_done_q;
    assign bus.rd_done = rd_done_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;

endmodule
